// File: rtl/lcd_hd44780_driver.sv
// HD44780 8-bit write-only bus driver: autonomous power-on init, then one byte per host request.
// Latency: lcd_e rises T_SETUP after accept, cmd_ready returns SETUP+PULSE+HOLD+WAIT later; cmd_ready=0 stalls the host.
module lcd_hd44780_driver #(
  parameter int T_SETUP_CYC   = 4,
  parameter int T_PULSE_CYC   = 25,
  parameter int T_HOLD_CYC    = 2,
  parameter int T_SHORT_CYC   = 4000,
  parameter int T_LONG_CYC    = 153000,
  parameter int T_INIT1_CYC   = 410000,
  parameter int T_POWERUP_CYC = 1500000,
  parameter bit SKIP_INIT     = 1'b0
) (
  input  logic       ACLK,
  input  logic       ARESET,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rs,
  input  logic [7:0] cmd_data,
  output logic       busy,
  output logic       init_done,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_d
);

  localparam int P_SETUP   = (T_SETUP_CYC   < 1) ? 1 : T_SETUP_CYC;
  localparam int P_PULSE   = (T_PULSE_CYC   < 1) ? 1 : T_PULSE_CYC;
  localparam int P_HOLD    = (T_HOLD_CYC    < 1) ? 1 : T_HOLD_CYC;
  localparam int P_SHORT   = (T_SHORT_CYC   < 1) ? 1 : T_SHORT_CYC;
  localparam int P_LONG    = (T_LONG_CYC    < 1) ? 1 : T_LONG_CYC;
  localparam int P_INIT1   = (T_INIT1_CYC   < 1) ? 1 : T_INIT1_CYC;
  localparam int P_POWERUP = (T_POWERUP_CYC < 1) ? 1 : T_POWERUP_CYC;

  localparam int M_A  = (P_SETUP > P_PULSE) ? P_SETUP : P_PULSE;
  localparam int M_B  = (P_HOLD > P_SHORT) ? P_HOLD : P_SHORT;
  localparam int M_C  = (P_LONG > P_INIT1) ? P_LONG : P_INIT1;
  localparam int M_D  = (M_A > M_B) ? M_A : M_B;
  localparam int M_E  = (M_C > P_POWERUP) ? M_C : P_POWERUP;
  localparam int MAXT = (M_D > M_E) ? M_D : M_E;
  localparam int CW   = $clog2(MAXT) + 1;

  typedef logic [CW-1:0] cnt_t;

  // Counter holds remaining cycles minus one, so each state lasts exactly its parameter.
  localparam cnt_t L_SETUP   = cnt_t'(P_SETUP - 1);
  localparam cnt_t L_PULSE   = cnt_t'(P_PULSE - 1);
  localparam cnt_t L_HOLD    = cnt_t'(P_HOLD - 1);
  localparam cnt_t L_SHORT   = cnt_t'(P_SHORT - 1);
  localparam cnt_t L_LONG    = cnt_t'(P_LONG - 1);
  localparam cnt_t L_INIT1   = cnt_t'(P_INIT1 - 1);
  localparam cnt_t L_POWERUP = cnt_t'(P_POWERUP - 1);

  typedef enum logic [2:0] {
    S_POWERUP, S_INIT_ISSUE, S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT
  } state_t;

  state_t     r_state;
  cnt_t       r_cnt;
  logic [2:0] r_idx;
  logic       r_rs;
  logic [7:0] r_d;
  logic       r_e;
  logic       r_ready;
  logic       r_busy;
  logic       r_done;

  logic       w_long;
  cnt_t       w_wait_load;
  logic [7:0] w_rom;

  always_comb begin
    w_rom = 8'h30;
    case (r_idx)
      3'd3:    w_rom = 8'h38;
      3'd4:    w_rom = 8'h0C;
      3'd5:    w_rom = 8'h01;
      3'd6:    w_rom = 8'h06;
      default: w_rom = 8'h30;
    endcase
  end

  assign w_long      = !r_rs && ((r_d == 8'h01) || (r_d == 8'h02) || (r_d == 8'h03));
  assign w_wait_load = (!r_done && (r_idx == 3'd0)) ? L_INIT1 :
                       w_long                       ? L_LONG  : L_SHORT;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state <= SKIP_INIT ? S_IDLE : S_POWERUP;
      r_cnt   <= L_POWERUP;
      r_idx   <= 3'd0;
      r_rs    <= 1'b0;
      r_d     <= 8'h00;
      r_e     <= 1'b0;
      r_ready <= SKIP_INIT;
      r_busy  <= !SKIP_INIT;
      r_done  <= SKIP_INIT;
    end else begin
      case (r_state)
        S_POWERUP: begin
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
          else r_state <= S_INIT_ISSUE;
        end
        S_INIT_ISSUE: begin
          r_rs    <= 1'b0;
          r_d     <= w_rom;
          r_cnt   <= L_SETUP;
          r_state <= S_SETUP;
        end
        S_IDLE: begin
          if (cmd_valid && r_ready) begin
            r_rs    <= cmd_rs;
            r_d     <= cmd_data;
            r_cnt   <= L_SETUP;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
          else begin
            r_e     <= 1'b1;
            r_cnt   <= L_PULSE;
            r_state <= S_PULSE;
          end
        end
        S_PULSE: begin
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
          else begin
            r_e     <= 1'b0;
            r_cnt   <= L_HOLD;
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
          else begin
            r_cnt   <= w_wait_load;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
          else if (!r_done && (r_idx != 3'd6)) begin
            r_idx   <= r_idx + 1'b1;
            r_state <= S_INIT_ISSUE;
          end else begin
            r_done  <= 1'b1;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_POWERUP;
      endcase
    end
  end

  assign cmd_ready = r_ready;
  assign busy      = r_busy;
  assign init_done = r_done;
  assign lcd_rs    = r_rs;
  assign lcd_rw    = 1'b0;
  assign lcd_e     = r_e;
  assign lcd_d     = r_d;

endmodule

// File: tb/tb_lcd_hd44780_driver.sv
// Bench for lcd_hd44780_driver: timeline model of captures and pulses checked every cycle,
// plus directed literal checks of init bytes, spacings, latencies, reset and queued requests.
module tb_lcd_hd44780_driver;

  localparam int S  = 3;
  localparam int P  = 4;
  localparam int H  = 2;
  localparam int SH = 6;
  localparam int LG = 15;
  localparam int I1 = 20;
  localparam int PU = 10;

  logic       ACLK = 1'b0;
  logic       ARESET = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_rs = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ready, busy, init_done, lcd_rs, lcd_rw, lcd_e;
  logic [7:0] lcd_d;

  logic       s_valid = 1'b0;
  logic       s_rs = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_ready, s_busy, s_done, s_lcd_rs, s_lcd_rw, s_lcd_e;
  logic [7:0] s_lcd_d;

  int n_chk = 0;
  int n_pass = 0;

  lcd_hd44780_driver #(
    .T_SETUP_CYC(S), .T_PULSE_CYC(P), .T_HOLD_CYC(H), .T_SHORT_CYC(SH),
    .T_LONG_CYC(LG), .T_INIT1_CYC(I1), .T_POWERUP_CYC(PU), .SKIP_INIT(1'b0)
  ) u_dut (
    .ACLK(ACLK), .ARESET(ARESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rs(cmd_rs), .cmd_data(cmd_data), .busy(busy), .init_done(init_done),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_d(lcd_d)
  );

  lcd_hd44780_driver #(
    .T_SETUP_CYC(S), .T_PULSE_CYC(P), .T_HOLD_CYC(H), .T_SHORT_CYC(SH),
    .T_LONG_CYC(LG), .T_INIT1_CYC(I1), .T_POWERUP_CYC(PU), .SKIP_INIT(1'b1)
  ) u_skip (
    .ACLK(ACLK), .ARESET(ARESET), .cmd_valid(s_valid), .cmd_ready(s_ready),
    .cmd_rs(s_rs), .cmd_data(s_data), .busy(s_busy), .init_done(s_done),
    .lcd_rs(s_lcd_rs), .lcd_rw(s_lcd_rw), .lcd_e(s_lcd_e), .lcd_d(s_lcd_d)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  logic [7:0] rom [7] = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h0C, 8'h01, 8'h06};

  // Timeline model: each byte written at edge m_cap has E high on edges
  // [m_cap+S, m_cap+S+P) and frees the block at m_cap+S+P+H+wait.
  int         m_n, m_cap, m_w, m_issue, m_idx;
  logic       m_ready, m_done, m_rs;
  logic [7:0] m_d;

  function automatic int wait_for(input logic done, input int idx, input logic rs, input logic [7:0] d);
    if (!done && idx == 0) return I1;
    if (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) return LG;
    return SH;
  endfunction

  always @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      m_n = 0; m_cap = -1000; m_w = 0; m_issue = PU + 1; m_idx = 0;
      m_ready = 1'b0; m_done = 1'b0; m_rs = 1'b0; m_d = 8'h00;
    end else begin
      m_n++;
      if (m_ready && cmd_valid) begin
        m_cap = m_n; m_rs = cmd_rs; m_d = cmd_data; m_ready = 1'b0;
        m_w = wait_for(m_done, m_idx, m_rs, m_d);
      end else if (!m_done && m_n == m_issue) begin
        m_cap = m_n; m_rs = 1'b0; m_d = rom[m_idx];
        m_w = wait_for(m_done, m_idx, m_rs, m_d);
      end
      if (!m_ready && m_cap > 0 && m_n == m_cap + S + P + H + m_w) begin
        if (m_done) m_ready = 1'b1;
        else if (m_idx == 6) begin m_done = 1'b1; m_ready = 1'b1; end
        else begin m_idx++; m_issue = m_n + 1; end
      end
    end
  end

  always @(negedge ACLK) begin
    chk("lcd_e", int'(lcd_e), int'(m_n >= m_cap + S && m_n < m_cap + S + P));
    chk("lcd_d", int'(lcd_d), int'(m_d));
    chk("lcd_rs", int'(lcd_rs), int'(m_rs));
    chk("lcd_rw", int'(lcd_rw), 0);
    chk("cmd_ready", int'(cmd_ready), int'(m_ready));
    chk("busy", int'(busy), int'(!m_ready));
    chk("init_done", int'(init_done), int'(m_done));
  end

  // Pulse log: edge index of each E rise, byte on the bus, and pulse width.
  int         cyc;
  logic       prev_e;
  int         rise_at;
  int         rq[$];
  logic [7:0] dq[$];
  logic       rsq[$];
  int         wq[$];

  always @(posedge ACLK or posedge ARESET) begin
    if (ARESET) cyc <= 0;
    else cyc <= cyc + 1;
  end

  always @(negedge ACLK) begin
    if (ARESET) prev_e <= 1'b0;
    else begin
      if (lcd_e && !prev_e) begin
        rise_at = cyc; rq.push_back(cyc); dq.push_back(lcd_d); rsq.push_back(lcd_rs);
      end
      if (!lcd_e && prev_e) wq.push_back(cyc - rise_at);
      prev_e <= lcd_e;
    end
  end

  task automatic clear_log();
    rq.delete(); dq.delete(); rsq.delete(); wq.delete();
  endtask

  // Called at a negedge with cmd_valid high; returns just after the accepting edge's negedge.
  task automatic accept(input string nm, output int acc);
    int b;
    b = 0;
    while (!cmd_ready && b < 600) begin @(negedge ACLK); b++; end
    if (!cmd_ready) chk({nm, "_accept_timeout"}, 0, 1);
    @(posedge ACLK);
    #1 acc = cyc;
    @(negedge ACLK);
  endtask

  task automatic wait_ready(input string nm, output int lat);
    lat = 0;
    while (!cmd_ready && lat < 300) begin @(posedge ACLK); lat++; @(negedge ACLK); end
    if (!cmd_ready) chk({nm, "_ready_timeout"}, 0, 1);
  endtask

  task automatic send(input string nm, input logic rs, input logic [7:0] d, output int lat, output int acc);
    @(negedge ACLK);
    cmd_valid = 1'b1; cmd_rs = rs; cmd_data = d;
    accept(nm, acc);
    cmd_valid = 1'b0;
    chk({nm, "_captured_d"}, int'(lcd_d), int'(d));
    chk({nm, "_captured_rs"}, int'(lcd_rs), int'(rs));
    wait_ready(nm, lat);
  endtask

  int lat, acc, eh, b;
  logic [7:0] bytes3 [3] = '{8'h48, 8'h69, 8'h21};
  logic [7:0] t3_d [4] = '{8'h01, 8'h80, 8'h02, 8'h03};
  int         t3_l [4] = '{S + P + H + LG, S + P + H + SH, S + P + H + LG, S + P + H + LG};
  int         init_gap [6] = '{30, 16, 16, 16, 16, 25};

  initial begin
    repeat (3) @(negedge ACLK);
    chk("rst_ready", int'(cmd_ready), 0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_init_done", int'(init_done), 0);
    chk("rst_lcd_e", int'(lcd_e), 0);
    chk("rst_lcd_d", int'(lcd_d), 0);
    chk("skip_rst_done", int'(s_done), 1);
    #2 ARESET = 1'b0;

    // SKIP_INIT instance: idle immediately, one data write of 0x41.
    @(negedge ACLK);
    chk("skip_ready", int'(s_ready), 1);
    chk("skip_busy", int'(s_busy), 0);
    chk("skip_done", int'(s_done), 1);
    s_valid = 1'b1; s_rs = 1'b1; s_data = 8'h41;
    @(posedge ACLK);
    @(negedge ACLK);
    s_valid = 1'b0;
    chk("skip_rs", int'(s_lcd_rs), 1);
    chk("skip_d", int'(s_lcd_d), 8'h41);
    chk("skip_ready_drop", int'(s_ready), 0);
    lat = 0; eh = 0;
    while (!s_ready && lat < 100) begin
      @(posedge ACLK); lat++; @(negedge ACLK);
      if (s_lcd_e) eh++;
    end
    chk("skip_latency", lat, 15);
    chk("skip_e_width", eh, 4);

    // Power-on init sequence.
    b = 0;
    while (!init_done && b < 600) begin @(negedge ACLK); b++; end
    chk("init_done_seen", int'(init_done), 1);
    chk("init_ready_with_done", int'(cmd_ready), 1);
    chk("init_pulses", rq.size(), 7);
    if (rq.size() == 7) begin
      for (int i = 0; i < 7; i++) begin
        chk($sformatf("init_d%0d", i), int'(dq[i]), int'(rom[i]));
        chk($sformatf("init_rs%0d", i), int'(rsq[i]), 0);
        chk($sformatf("init_w%0d", i), wq[i], P);
      end
      for (int i = 0; i < 6; i++) chk($sformatf("init_gap%0d", i), rq[i+1] - rq[i], init_gap[i]);
    end

    // Single data write.
    clear_log();
    send("data41", 1'b1, 8'h41, lat, acc);
    chk("data41_latency", lat, 15);
    chk("data41_pulses", rq.size(), 1);
    if (rq.size() == 1) begin
      chk("data41_e_delay", rq[0] - acc, S);
      chk("data41_e_width", wq[0], P);
    end

    // Long vs short instructions.
    for (int i = 0; i < 4; i++) begin
      send($sformatf("ins%02h", t3_d[i]), 1'b0, t3_d[i], lat, acc);
      chk($sformatf("ins%02h_latency", t3_d[i]), lat, t3_l[i]);
    end

    // Three queued bytes with cmd_valid held high.
    clear_log();
    @(negedge ACLK);
    cmd_valid = 1'b1; cmd_rs = 1'b1; cmd_data = bytes3[0];
    for (int i = 0; i < 3; i++) begin
      accept("b2b", acc);
      if (i < 2) cmd_data = bytes3[i+1];
      else cmd_valid = 1'b0;
    end
    wait_ready("b2b", lat);
    chk("b2b_pulses", rq.size(), 3);
    if (rq.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("b2b_d%0d", i), int'(dq[i]), int'(bytes3[i]));
        chk($sformatf("b2b_w%0d", i), wq[i], P);
      end
      chk("b2b_gap0", rq[1] - rq[0], S + P + H + SH + 1);
      chk("b2b_gap1", rq[2] - rq[1], S + P + H + SH + 1);
    end

    // Reset in the middle of a pulse, with a request pending across reset and init.
    @(negedge ACLK);
    cmd_valid = 1'b1; cmd_rs = 1'b1; cmd_data = 8'h22;
    accept("midrst", acc);
    cmd_valid = 1'b0;
    b = 0;
    while (!lcd_e && b < 50) begin @(negedge ACLK); b++; end
    chk("midrst_in_pulse", int'(lcd_e), 1);
    #2 ARESET = 1'b1;
    #1;
    chk("midrst_e_low", int'(lcd_e), 0);
    chk("midrst_done_low", int'(init_done), 0);
    chk("midrst_ready_low", int'(cmd_ready), 0);
    cmd_valid = 1'b1; cmd_rs = 1'b1; cmd_data = 8'h55;
    repeat (2) @(negedge ACLK);
    clear_log();
    #2 ARESET = 1'b0;
    b = 0;
    while (!init_done && b < 600) begin @(negedge ACLK); b++; end
    chk("rerun_done", int'(init_done), 1);
    chk("rerun_no_early_xfer", rq.size(), 7);
    accept("pending", acc);
    cmd_valid = 1'b0;
    wait_ready("pending", lat);
    chk("pending_pulses", rq.size(), 8);
    if (rq.size() == 8) begin
      chk("rerun_first_d", int'(dq[0]), 8'h30);
      chk("rerun_last_init_d", int'(dq[6]), 8'h06);
      chk("pending_d", int'(dq[7]), 8'h55);
      chk("pending_rs", int'(rsq[7]), 1);
    end
    chk("pending_latency", lat, S + P + H + SH);

    repeat (2) @(negedge ACLK);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lcd_hd44780_driver.md
Name: lcd_hd44780_driver

Overview:
- Downstream stage of the AXI4-Lite LCD register slave. The slave decodes register writes into single-byte command/data requests, and this block consumes them.
- Drives a write-only 8-bit HD44780 character-LCD bus (RS, RW, E, D[7:0]) with programmable setup, pulse, hold and execution-wait timing.
- After reset, runs the standard power-on initialisation sequence autonomously before accepting any request.

Parameters:
- T_SETUP_CYC, 4: cycles RS/D are stable before E rises (tAS).
- T_PULSE_CYC, 25: cycles E is high (PWEH).
- T_HOLD_CYC, 2: cycles RS/D are held after E falls.
- T_SHORT_CYC, 4000: execution wait for ordinary commands and data (40 us at 100 MHz).
- T_LONG_CYC, 153000: execution wait for clear/home (1.53 ms).
- T_INIT1_CYC, 410000: wait after the first 0x30 of the init sequence (4.1 ms).
- T_POWERUP_CYC, 1500000: delay from reset release to the first init write (15 ms).
- SKIP_INIT, 0: 1 means go directly from reset to IDLE with init_done=1 (simulation only).

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  asynchronous reset, active-high.
- cmd_valid  in  1  request valid.
- cmd_ready  out  1  block can accept a request.
- cmd_rs  in  1  0 = instruction, 1 = data.
- cmd_data  in  8  byte to write.
- busy  out  1  high whenever state is not IDLE.
- init_done  out  1  init sequence complete; sticky until reset.
- lcd_rs  out  1  LCD register select.
- lcd_rw  out  1  LCD read/write; tied 0.
- lcd_e  out  1  LCD enable strobe.
- lcd_d  out  8  LCD data bus.

Behaviour:
- Reset values: cmd_ready=0, busy=1, init_done=0, lcd_rs=0, lcd_rw=0, lcd_e=0, lcd_d=0x00. Exception: with SKIP_INIT=1, init_done=1, busy=0 and cmd_ready=1 immediately after reset release.
- States: POWERUP, INIT_ISSUE, IDLE, SETUP, PULSE, HOLD, WAIT.
- A single down-counter times every state. Its width is $clog2 of the largest timing parameter, plus 1.
- POWERUP: counts T_POWERUP_CYC, then goes to INIT_ISSUE.
- Init ROM, index 0..6: 0x30, 0x30, 0x30, 0x38, 0x0C, 0x01, 0x06, all with RS=0.
- INIT_ISSUE: loads ROM[idx] into the rs/data registers, then goes to SETUP.
- End of each init WAIT: idx increments. After idx 6, init_done=1 and the next state is IDLE.
- IDLE: cmd_ready=1. A transfer occurs on the edge where cmd_valid&&cmd_ready. On that edge the block captures cmd_rs/cmd_data into lcd_rs/lcd_d and moves to SETUP. cmd_ready is 0 from the following cycle.
- SETUP: lasts T_SETUP_CYC cycles, then PULSE.
- PULSE: lasts T_PULSE_CYC cycles with lcd_e=1, then HOLD. lcd_e is high only in PULSE.
- HOLD: lasts T_HOLD_CYC cycles, then WAIT.
- lcd_rs and lcd_d stay constant from capture through the end of HOLD. They remain unchanged until the next capture.
- WAIT duration selection:
  - init idx 0: T_INIT1_CYC.
  - otherwise, RS=0 and data in {0x01, 0x02, 0x03}: T_LONG_CYC.
  - all other cases: T_SHORT_CYC.
- Host-request latency: cmd_ready re-asserts exactly T_SETUP+T_PULSE+T_HOLD+WAIT cycles after the accepting edge. lcd_e rises T_SETUP cycles after that edge.
- cmd_valid while cmd_ready=0 is ignored; the upstream block holds the request. No request is dropped and none is accepted during init.
- Back-to-back requests: if cmd_valid is held high, the next transfer occurs on the first IDLE cycle.
- ARESET mid-operation: all outputs return to their reset values asynchronously, lcd_e falls immediately, and the init sequence restarts from POWERUP.
- Counter compare uses cycle counts directly. A timing parameter of 0 is illegal; the implementation clamps it to 1.

Test Plan:
1. Reset then release, with SKIP_INIT=0 and all timing parameters scaled to 2..20 cycles:
   - lcd_e pulses 7 times with lcd_d = 30, 30, 30, 38, 0C, 01, 06 (hex), lcd_rs=0.
   - Spacing between pulses matches T_INIT1 / short / long exactly.
   - init_done and cmd_ready rise together after the last wait.
2. SKIP_INIT=1, write cmd_rs=1, cmd_data=0x41:
   - lcd_rs=1 and lcd_d=0x41 on the next cycle.
   - lcd_e high for exactly T_PULSE_CYC cycles, starting T_SETUP_CYC cycles after the accepting edge.
   - cmd_ready returns after SETUP+PULSE+HOLD+T_SHORT.
3. Instruction 0x01, then instruction 0x80:
   - Gap to cmd_ready is T_LONG for 0x01 and T_SHORT for 0x80.
   - 0x02 and 0x03 also use T_LONG.
4. cmd_valid held high with 3 data bytes queued:
   - Exactly 3 E pulses with correct data and no overlap.
   - lcd_d never changes while lcd_e=1 or during HOLD.
5. Assert ARESET in the middle of PULSE:
   - lcd_e=0 in the same cycle; init_done=0, cmd_ready=0.
   - The init sequence reruns from the beginning after release.
6. cmd_valid asserted during init:
   - No transfer occurs until init_done=1.
   - The first post-init pulse carries the pending byte.
